// File: rtl/imem_boot_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
// Imported by the loader top level and its word packer.
package imem_boot_pkg;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_HEADER = 3'd1,
      S_BYTES  = 3'd2,
      S_WRITE  = 3'd3,
      S_DONE   = 3'd4,
      S_ERROR  = 3'd5
   } state_e;

   localparam int BYTES_PER_WORD  = 4;
   localparam int TIMEOUT_DEFAULT = 1000000;

endpackage

// File: rtl/imem_word_packer.sv
// Assembles little-endian bytes into one instruction word.
// Flags the byte that completes the word.
module imem_word_packer
   import imem_boot_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              clear_i,
   input  logic              load_i,
   input  logic [7:0]        byte_i,
   output logic [DATA_W-1:0] wdata_o,
   output logic              word_full_o
);

   localparam int IW = $clog2(BYTES_PER_WORD);

   logic [IW-1:0]     idx_q, idx_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;

   // Place each accepted byte in its lane and advance the lane index
   always_comb begin
      idx_d   = idx_q;
      wdata_d = wdata_q;
      if (clear_i) begin
         idx_d = '0;
      end else if (load_i) begin
         wdata_d[8*idx_q +: 8] = byte_i;
         idx_d = idx_q + IW'(1);
      end
   end

   // Lane index and word register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         idx_q   <= '0;
         wdata_q <= '0;
      end else begin
         idx_q   <= idx_d;
         wdata_q <= wdata_d;
      end
   end

   assign wdata_o     = wdata_q;
   assign word_full_o = load_i && (idx_q == IW'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_boot_loader.sv
// Boot loader: streams a program into instruction memory while the core
// is held in reset, then hands the memory read port back to the core.
module imem_boot_loader
   import imem_boot_pkg::*;
#(
   parameter int ADDR_W  = 8,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              start_i,
   input  logic              skip_i,
   input  logic              byte_valid_i,
   input  logic [7:0]        byte_data_i,
   output logic              byte_ready_o,
   input  logic [ADDR_W-1:0] cpu_addr_i,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic              mem_we_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   output logic              core_rst_no,
   output logic              busy_o,
   output logic              done_o,
   output logic              err_o
);

   localparam int TW = $clog2(TIMEOUT + 1);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] waddr_q, waddr_d;
   logic [ADDR_W-1:0] count_q, count_d;
   logic [TW-1:0]     tmo_q, tmo_d;

   logic accept;
   logic hdr_take;
   logic byte_take;
   logic word_full;

   assign accept    = byte_valid_i && byte_ready_o;
   assign hdr_take  = accept && (state_q == S_HEADER);
   assign byte_take = accept && (state_q == S_BYTES);

   imem_word_packer #(
      .DATA_W (DATA_W)
   ) u_packer (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .clear_i     (hdr_take),
      .load_i      (byte_take),
      .byte_i      (byte_data_i),
      .wdata_o     (mem_wdata_o),
      .word_full_o (word_full)
   );

   // Next state, address/count bookkeeping and idle-gap counter
   always_comb begin
      state_d = state_q;
      waddr_d = waddr_q;
      count_d = count_q;
      tmo_d   = '0;
      unique case (state_q)
         S_IDLE: begin
            if (start_i) begin
               state_d = S_HEADER;
            end else if (skip_i) begin
               state_d = S_DONE;
            end
         end
         S_HEADER: begin
            if (hdr_take) begin
               count_d = ADDR_W'(byte_data_i);
               waddr_d = '0;
               state_d = S_BYTES;
            end
         end
         S_BYTES: begin
            if (byte_take) begin
               if (word_full) begin
                  state_d = S_WRITE;
               end
            end else if (tmo_q == TW'(TIMEOUT - 1)) begin
               state_d = S_ERROR;
            end else begin
               tmo_d = tmo_q + TW'(1);
            end
         end
         S_WRITE: begin
            if (waddr_q == count_q) begin
               state_d = S_DONE;
            end else begin
               waddr_d = waddr_q + ADDR_W'(1);
               state_d = S_BYTES;
            end
         end
         S_DONE, S_ERROR: begin
            if (start_i) begin
               state_d = S_HEADER;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and counter registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= S_IDLE;
         waddr_q <= '0;
         count_q <= '0;
         tmo_q   <= '0;
      end else begin
         state_q <= state_d;
         waddr_q <= waddr_d;
         count_q <= count_d;
         tmo_q   <= tmo_d;
      end
   end

   assign byte_ready_o = (state_q == S_HEADER) || (state_q == S_BYTES);
   assign busy_o       = byte_ready_o || (state_q == S_WRITE);
   assign mem_we_o     = (state_q == S_WRITE);
   assign done_o       = (state_q == S_DONE);
   assign core_rst_no  = (state_q == S_DONE);
   assign err_o        = (state_q == S_ERROR);
   assign mem_addr_o   = busy_o ? waddr_q : cpu_addr_i;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for the boot loader with a small write log.
// Inputs change on the falling edge; outputs are sampled there too.
module tb_imem_boot_loader;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic        skip;
   logic        byte_valid;
   logic [7:0]  byte_data;
   logic        byte_ready;
   logic [7:0]  cpu_addr;
   logic [7:0]  mem_addr;
   logic        mem_we;
   logic [31:0] mem_wdata;
   logic        core_rst_n;
   logic        busy;
   logic        done;
   logic        err;

   int checks = 0;
   int errors = 0;

   int          wr_n = 0;
   logic [7:0]  wr_addr [0:511];
   logic [31:0] wr_data [0:511];

   imem_boot_loader #(
      .ADDR_W  (8),
      .DATA_W  (32),
      .TIMEOUT (16)
   ) dut (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .start_i      (start),
      .skip_i       (skip),
      .byte_valid_i (byte_valid),
      .byte_data_i  (byte_data),
      .byte_ready_o (byte_ready),
      .cpu_addr_i   (cpu_addr),
      .mem_addr_o   (mem_addr),
      .mem_we_o     (mem_we),
      .mem_wdata_o  (mem_wdata),
      .core_rst_no  (core_rst_n),
      .busy_o       (busy),
      .done_o       (done),
      .err_o        (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (mem_we === 1'b1 && wr_n < 512) begin
         wr_addr[wr_n] = mem_addr;
         wr_data[wr_n] = mem_wdata;
         wr_n = wr_n + 1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      int n;
      n = 0;
      byte_valid = 1'b1;
      byte_data  = b;
      while (byte_ready !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) chk("byte_accept_timeout", 32'(n), 32'd0);
      @(negedge clk);
      byte_valid = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w);
      for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   function automatic logic [31:0] pat(input int k);
      logic [7:0] b;
      b = 8'(k);
      return {b, ~b, 8'h3C, b ^ 8'hC3};
   endfunction

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int bad;
      rst_n      = 1'b0;
      start      = 1'b0;
      skip       = 1'b0;
      byte_valid = 1'b0;
      byte_data  = 8'h00;
      cpu_addr   = 8'h55;
      @(negedge clk);
      @(negedge clk);

      // reset values
      chk("rst_ready", {31'd0, byte_ready}, 32'd0);
      chk("rst_we", {31'd0, mem_we}, 32'd0);
      chk("rst_wdata", mem_wdata, 32'd0);
      chk("rst_core", {31'd0, core_rst_n}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_err", {31'd0, err}, 32'd0);
      chk("rst_addr", {24'd0, mem_addr}, 32'h55);
      rst_n = 1'b1;
      @(negedge clk);

      // two-word load
      pulse_start();
      chk("hdr_busy", {31'd0, busy}, 32'd1);
      chk("hdr_ready", {31'd0, byte_ready}, 32'd1);
      send_byte(8'h01);
      send_byte(8'h13);
      send_byte(8'h03);
      send_byte(8'h00);
      send_byte(8'h03);
      chk("w0_we", {31'd0, mem_we}, 32'd1);
      chk("w0_ready", {31'd0, byte_ready}, 32'd0);
      chk("w0_addr", {24'd0, mem_addr}, 32'h00);
      chk("w0_data", mem_wdata, 32'h03000313);
      send_byte(8'h93);
      send_byte(8'h03);
      send_byte(8'hc0);
      send_byte(8'h00);
      chk("w1_we", {31'd0, mem_we}, 32'd1);
      chk("w1_addr", {24'd0, mem_addr}, 32'h01);
      chk("w1_data", mem_wdata, 32'h00c00393);
      chk("w1_done_early", {31'd0, done}, 32'd0);
      chk("w1_core_early", {31'd0, core_rst_n}, 32'd0);
      @(negedge clk);
      chk("ld2_done", {31'd0, done}, 32'd1);
      chk("ld2_core", {31'd0, core_rst_n}, 32'd1);
      chk("ld2_busy", {31'd0, busy}, 32'd0);
      chk("ld2_writes", 32'(wr_n), 32'd2);
      chk("ld2_addr_mux", {24'd0, mem_addr}, 32'h55);

      // reload from DONE
      wr_n = 0;
      start = 1'b1;
      chk("rl_core_pre", {31'd0, core_rst_n}, 32'd1);
      @(negedge clk);
      start = 1'b0;
      chk("rl_busy", {31'd0, busy}, 32'd1);
      chk("rl_core", {31'd0, core_rst_n}, 32'd0);
      send_byte(8'h00);
      send_word(32'hDEADBEEF);
      @(negedge clk);
      chk("rl_done", {31'd0, done}, 32'd1);
      chk("rl_writes", 32'(wr_n), 32'd1);
      chk("rl_wr_addr", {24'd0, wr_addr[0]}, 32'h00);
      chk("rl_wr_data", wr_data[0], 32'hDEADBEEF);

      // skip path and ignored bytes
      do_reset();
      wr_n = 0;
      cpu_addr = 8'h2A;
      skip = 1'b1;
      @(negedge clk);
      skip = 1'b0;
      chk("skip_done", {31'd0, done}, 32'd1);
      chk("skip_core", {31'd0, core_rst_n}, 32'd1);
      chk("skip_addr", {24'd0, mem_addr}, 32'h2A);
      byte_valid = 1'b1;
      byte_data  = 8'h77;
      repeat (3) @(negedge clk);
      byte_valid = 1'b0;
      chk("skip_ignore_done", {31'd0, done}, 32'd1);
      chk("skip_writes", 32'(wr_n), 32'd0);

      // timeout
      do_reset();
      wr_n = 0;
      pulse_start();
      send_byte(8'h00);
      send_byte(8'h11);
      send_byte(8'h22);
      repeat (15) @(negedge clk);
      chk("tmo_err_early", {31'd0, err}, 32'd0);
      @(negedge clk);
      chk("tmo_err", {31'd0, err}, 32'd1);
      chk("tmo_core", {31'd0, core_rst_n}, 32'd0);
      chk("tmo_ready", {31'd0, byte_ready}, 32'd0);
      chk("tmo_writes", 32'(wr_n), 32'd0);
      pulse_start();
      chk("err_restart", {31'd0, busy}, 32'd1);

      // full 256-word load with gaps
      do_reset();
      wr_n = 0;
      pulse_start();
      send_byte(8'hFF);
      for (int k = 0; k < 256; k++) begin
         logic [31:0] w;
         w = pat(k);
         for (int i = 0; i < 4; i++) begin
            repeat ($urandom_range(1, 3)) @(negedge clk);
            send_byte(w[8*i +: 8]);
         end
      end
      @(negedge clk);
      chk("full_done", {31'd0, done}, 32'd1);
      chk("full_writes", 32'(wr_n), 32'd256);
      bad = 0;
      for (int k = 0; k < 256; k++) begin
         if (wr_addr[k] !== 8'(k) || wr_data[k] !== pat(k)) bad++;
      end
      chk("full_seq", 32'(bad), 32'd0);

      // reset in the middle of a load
      do_reset();
      wr_n = 0;
      cpu_addr = 8'h3C;
      pulse_start();
      send_byte(8'h04);
      send_word(32'h11111111);
      send_word(32'h22222222);
      send_word(32'h33333333);
      @(negedge clk);
      chk("mid_writes", 32'(wr_n), 32'd3);
      chk("mid_busy_pre", {31'd0, busy}, 32'd1);
      rst_n = 1'b0;
      #1;
      chk("mid_busy", {31'd0, busy}, 32'd0);
      chk("mid_ready", {31'd0, byte_ready}, 32'd0);
      chk("mid_we", {31'd0, mem_we}, 32'd0);
      chk("mid_wdata", mem_wdata, 32'd0);
      chk("mid_core", {31'd0, core_rst_n}, 32'd0);
      chk("mid_done", {31'd0, done}, 32'd0);
      chk("mid_err", {31'd0, err}, 32'd0);
      chk("mid_addr", {24'd0, mem_addr}, 32'h3C);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      wr_n = 0;
      pulse_start();
      send_byte(8'h00);
      send_word(32'hCAFEF00D);
      @(negedge clk);
      chk("post_done", {31'd0, done}, 32'd1);
      chk("post_writes", 32'(wr_n), 32'd1);
      chk("post_wr_addr", {24'd0, wr_addr[0]}, 32'h00);
      chk("post_wr_data", wr_data[0], 32'hCAFEF00D);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
